// File: rtl/jala_pkg.sv
// jala_pkg: shared opcodes, ALU encodings and ID/EX record for the Jala RV32I pipeline
package jala_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        src_imm;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic [2:0]  funct3;
    logic        reg_write;
  } id_ex_t;

  // alt selects SUB on funct3=0 and SRA on funct3=5
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended I/S/B/U/J immediate from an RV32I instruction word
module imm_gen
  import jala_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm
);

  logic [6:0] w_op;
  assign w_op = i_instr[6:0];

  // pick the immediate layout from the opcode; formats without one yield 0
  always_comb begin
    o_imm = (w_op == OP_IMM || w_op == OP_LOAD || w_op == OP_JALR) ? {{20{i_instr[31]}}, i_instr[31:20]} :
            (w_op == OP_STORE)  ? {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]} :
            (w_op == OP_BRANCH) ? {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
            (w_op == OP_LUI || w_op == OP_AUIPC) ? {i_instr[31:12], 12'b0} :
            (w_op == OP_JAL)    ? {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
            32'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I ID stage with registered ID/EX boundary, load-use bubble and flush; DECODE_ILLEGAL_TRAP_EN adds o_ex_illegal
module decode_stage
  import jala_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
)
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_if_valid,
  output logic            o_if_ready,
  input  logic [31:0]     i_if_instr,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic            i_flush,
  output logic [4:0]      o_rf_read_addr1,
  output logic [4:0]      o_rf_read_addr2,
  input  logic [XLEN-1:0] i_rf_read_data1,
  input  logic [XLEN-1:0] i_rf_read_data2,
  input  logic            i_ex_ready,
  output logic            o_ex_valid,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [XLEN-1:0] o_ex_rs1_data,
  output logic [XLEN-1:0] o_ex_rs2_data,
  output logic [XLEN-1:0] o_ex_imm,
  output logic [4:0]      o_ex_rd,
  output logic [3:0]      o_ex_alu_op,
  output logic            o_ex_src_imm,
  output logic            o_ex_is_load,
  output logic            o_ex_is_store,
  output logic            o_ex_is_branch,
  output logic            o_ex_is_jump,
  output logic [2:0]      o_ex_funct3,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic            o_ex_illegal,
`endif
  output logic            o_ex_reg_write
);

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic [3:0]  w_alu;
  logic        w_src_imm;
  logic        w_ld;
  logic        w_st;
  logic        w_br;
  logic        w_jmp;
  logic        w_rw;
  logic        w_use1;
  logic        w_use2;
  logic        w_bad;
  logic        w_adv;
  logic        w_haz;
  logic        w_take;
  id_ex_t      w_dec;
  id_ex_t      r_ex;
  logic        r_valid;

  assign w_op  = i_if_instr[6:0];
  assign w_f3  = i_if_instr[14:12];
  assign w_f7  = i_if_instr[31:25];
  assign w_rs1 = i_if_instr[19:15];
  assign w_rs2 = i_if_instr[24:20];
  assign w_rd  = i_if_instr[11:7];

  assign o_rf_read_addr1 = w_rs1;
  assign o_rf_read_addr2 = w_rs2;

  imm_gen u_imm (.i_instr(i_if_instr), .o_imm(w_imm));

  // opcode decode; anything illegal collapses to a side-effect-free NOP
  always_comb begin
    w_alu     = ALU_ADD;
    w_src_imm = 1'b0;
    w_ld      = 1'b0;
    w_st      = 1'b0;
    w_br      = 1'b0;
    w_jmp     = 1'b0;
    w_rw      = 1'b0;
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_bad     = 1'b0;
    case (w_op)
      OP_LUI:    begin w_alu = ALU_PASS_B; w_src_imm = 1'b1; w_rw = 1'b1; end
      OP_AUIPC:  begin w_src_imm = 1'b1; w_rw = 1'b1; end
      OP_JAL:    begin w_src_imm = 1'b1; w_rw = 1'b1; w_jmp = 1'b1; end
      OP_JALR:   begin w_src_imm = 1'b1; w_rw = 1'b1; w_jmp = 1'b1; w_use1 = 1'b1; w_bad = w_f3 != 3'd0; end
      OP_BRANCH: begin w_alu = ALU_SUB; w_br = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; w_bad = w_f3 == 3'd2 || w_f3 == 3'd3; end
      OP_LOAD:   begin w_src_imm = 1'b1; w_rw = 1'b1; w_ld = 1'b1; w_use1 = 1'b1; w_bad = w_f3 == 3'd3 || w_f3 > 3'd5; end
      OP_STORE:  begin w_src_imm = 1'b1; w_st = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; w_bad = w_f3 > 3'd2; end
      OP_IMM: begin
        w_alu     = alu_from_f3(w_f3, w_f3 == 3'd5 && i_if_instr[30]);
        w_src_imm = 1'b1;
        w_rw      = 1'b1;
        w_use1    = 1'b1;
        w_bad     = (w_f3 == 3'd1 && w_f7 != 7'h00) || (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20);
      end
      OP_REG: begin
        w_alu  = alu_from_f3(w_f3, i_if_instr[30]);
        w_rw   = 1'b1;
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_bad  = !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)));
      end
      OP_FENCE, OP_SYSTEM: ;
      default:   w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_rw   = 1'b0;
      w_ld   = 1'b0;
      w_st   = 1'b0;
      w_br   = 1'b0;
      w_jmp  = 1'b0;
      w_use1 = 1'b0;
      w_use2 = 1'b0;
    end
    if (w_rd == 5'd0) w_rw = 1'b0;
  end

  assign w_haz = r_valid && r_ex.is_load && r_ex.rd != 5'd0 &&
                 ((w_use1 && r_ex.rd == w_rs1) || (w_use2 && r_ex.rd == w_rs2));
  assign w_adv  = !r_valid || i_ex_ready;
  assign w_take = i_if_valid && !w_haz;
  assign o_if_ready = w_adv && !w_haz && !i_flush;

  assign w_dec = '{pc: i_if_pc, rs1_data: i_rf_read_data1, rs2_data: i_rf_read_data2, imm: w_imm,
                   rd: w_rd, alu_op: w_alu, src_imm: w_src_imm, is_load: w_ld, is_store: w_st,
                   is_branch: w_br, is_jump: w_jmp, funct3: w_f3, reg_write: w_rw};

  // ID/EX register: flush beats everything, a stalled execute holds the record
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_ex    <= '{pc: RESET_PC, default: '0};
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid <= w_take;
      if (w_take) r_ex <= w_dec;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic r_illegal;
  // illegal flag travels with the captured record
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_illegal <= 1'b0;
    else if (!i_flush && w_adv && w_take) r_illegal <= w_bad;
  end
  assign o_ex_illegal = r_illegal;
`endif

  assign o_ex_valid     = r_valid;
  assign o_ex_pc        = r_ex.pc;
  assign o_ex_rs1_data  = r_ex.rs1_data;
  assign o_ex_rs2_data  = r_ex.rs2_data;
  assign o_ex_imm       = r_ex.imm;
  assign o_ex_rd        = r_ex.rd;
  assign o_ex_alu_op    = r_ex.alu_op;
  assign o_ex_src_imm   = r_ex.src_imm;
  assign o_ex_is_load   = r_ex.is_load;
  assign o_ex_is_store  = r_ex.is_store;
  assign o_ex_is_branch = r_ex.is_branch;
  assign o_ex_is_jump   = r_ex.is_jump;
  assign o_ex_funct3    = r_ex.funct3;
  assign o_ex_reg_write = r_ex.reg_write;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage
module tb_decode_stage;
  import jala_pkg::*;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        src;
    logic        ld;
    logic        st;
    logic        br;
    logic        jmp;
    logic [2:0]  f3;
    logic        rw;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        flush = 1'b0;
  logic [4:0]  ra1, ra2;
  logic [31:0] rf1 = '0;
  logic [31:0] rf2 = '0;
  logic        ex_ready = 1'b1;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu;
  logic        ex_src, ex_ld, ex_st, ex_br, ex_jmp, ex_rw, ex_ill;
  logic [2:0]  ex_f3;
  exp_t        got;
  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  decode_stage dut (
    .i_clk(clk), .i_reset(reset), .i_if_valid(if_valid), .o_if_ready(if_ready),
    .i_if_instr(if_instr), .i_if_pc(if_pc), .i_flush(flush),
    .o_rf_read_addr1(ra1), .o_rf_read_addr2(ra2),
    .i_rf_read_data1(rf1), .i_rf_read_data2(rf2), .i_ex_ready(ex_ready),
    .o_ex_valid(ex_valid), .o_ex_pc(ex_pc), .o_ex_rs1_data(ex_rs1), .o_ex_rs2_data(ex_rs2),
    .o_ex_imm(ex_imm), .o_ex_rd(ex_rd), .o_ex_alu_op(ex_alu), .o_ex_src_imm(ex_src),
    .o_ex_is_load(ex_ld), .o_ex_is_store(ex_st), .o_ex_is_branch(ex_br), .o_ex_is_jump(ex_jmp),
    .o_ex_funct3(ex_f3),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .o_ex_illegal(ex_ill),
`endif
    .o_ex_reg_write(ex_rw)
  );

`ifndef DECODE_ILLEGAL_TRAP_EN
  assign ex_ill = 1'b0;
`endif

  assign got = '{pc: ex_pc, rs1: ex_rs1, rs2: ex_rs2, imm: ex_imm, rd: ex_rd, alu: ex_alu, src: ex_src,
                 ld: ex_ld, st: ex_st, br: ex_br, jmp: ex_jmp, f3: ex_f3, rw: ex_rw, ill: ex_ill};

  always #5 clk = ~clk;

  function automatic logic [31:0] d1(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] d2(input logic [31:0] pc);
    return pc ^ 32'h0000_5A5A;
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                              input logic [3:0] alu, input logic src, input logic ld, input logic st,
                              input logic br, input logic jmp, input logic [2:0] f3, input logic rw,
                              input logic ill);
    return '{pc: pc, rs1: d1(pc), rs2: d2(pc), imm: imm, rd: rd, alu: alu, src: src, ld: ld, st: st,
             br: br, jmp: jmp, f3: f3, rw: rw, ill: ill};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #2;
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
    rf1      = d1(pc);
    rf2      = d2(pc);
    ex_ready = rdy;
    flush    = fl;
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    drive(1'b1, ins, pc, 1'b1, 1'b0);
    chk($sformatf("if_ready pc=%0h", pc), 256'(if_ready), 256'(1'b1));
    q.push_back(e);
  endtask

  // monitor: every transfer to execute is matched against the next expected record
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ex_valid && ex_ready) begin
      if (q.size() == 0) begin
        chk("scoreboard unexpected transfer", 256'(got), 256'(0));
      end else begin
        e = q.pop_front();
        chk($sformatf("scoreboard pc=%0h", e.pc), 256'(got), 256'(e));
      end
    end
  end

  initial begin
    exp_t e_sw;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ex_valid", 256'(ex_valid), 256'(0));
    chk("reset ex_pc", 256'(ex_pc), 256'(0));
    chk("reset ex_imm", 256'(ex_imm), 256'(0));
    chk("reset ex_reg_write", 256'(ex_rw), 256'(0));
    @(negedge clk);
    reset = 1'b0;

    issue(32'hFFF00293, 32'h100, mk(32'h100, 32'hFFFFFFFF, 5'd5, ALU_ADD, 1, 0, 0, 0, 0, 3'd0, 1, 0));
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("addi latency ex_valid", 256'(ex_valid), 256'(1));
    chk("addi ex_imm", 256'(ex_imm), 256'(32'hFFFFFFFF));

    issue(32'h0000A303, 32'h104, mk(32'h104, 32'h0, 5'd6, ALU_ADD, 1, 1, 0, 0, 0, 3'd2, 1, 0));
    drive(1'b1, 32'h002303B3, 32'h108, 1'b1, 1'b0);
    chk("load-use if_ready", 256'(if_ready), 256'(0));
    chk("load-use lw held", 256'(ex_valid), 256'(1));
    issue(32'h002303B3, 32'h108, mk(32'h108, 32'h0, 5'd7, ALU_ADD, 0, 0, 0, 0, 0, 3'd0, 1, 0));
    chk("load-use bubble", 256'(ex_valid), 256'(0));
    issue(32'h0000A003, 32'h10C, mk(32'h10C, 32'h0, 5'd0, ALU_ADD, 1, 1, 0, 0, 0, 3'd2, 0, 0));
    issue(32'h002003B3, 32'h110, mk(32'h110, 32'h0, 5'd7, ALU_ADD, 0, 0, 0, 0, 0, 3'd0, 1, 0));
    chk("x0 load no bubble", 256'(ex_valid), 256'(1));

    e_sw = mk(32'h114, 32'h8, 5'd8, ALU_ADD, 1, 0, 1, 0, 0, 3'd2, 0, 0);
    issue(32'h0020A423, 32'h114, e_sw);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h00500093, 32'h118, 1'b0, 1'b0);
      chk($sformatf("stall %0d if_ready", i), 256'(if_ready), 256'(0));
      chk($sformatf("stall %0d hold", i), 256'(got), 256'(e_sw));
      chk($sformatf("stall %0d ex_valid", i), 256'(ex_valid), 256'(1));
    end
    issue(32'h00500093, 32'h118, mk(32'h118, 32'h5, 5'd1, ALU_ADD, 1, 0, 0, 0, 0, 3'd0, 1, 0));

    drive(1'b1, 32'h00700113, 32'h11C, 1'b1, 1'b1);
    chk("flush if_ready", 256'(if_ready), 256'(0));
    issue(32'h00900193, 32'h120, mk(32'h120, 32'h9, 5'd3, ALU_ADD, 1, 0, 0, 0, 0, 3'd0, 1, 0));
    chk("flush ex_valid", 256'(ex_valid), 256'(0));

    issue(32'hFE000EE3, 32'h124, mk(32'h124, 32'hFFFFFFFC, 5'd29, ALU_SUB, 0, 0, 0, 1, 0, 3'd0, 0, 0));
    issue(32'h001000EF, 32'h128, mk(32'h128, 32'h00000800, 5'd1, ALU_ADD, 1, 0, 0, 0, 1, 3'd0, 1, 0));
    chk("beq imm", 256'(ex_imm), 256'(32'hFFFFFFFC));
    issue(32'hABCDE537, 32'h12C, mk(32'h12C, 32'hABCDE000, 5'd10, ALU_PASS_B, 1, 0, 0, 0, 0, 3'd6, 1, 0));
    chk("jal imm", 256'(ex_imm), 256'(32'h00000800));
    issue(32'h402081B3, 32'h130, mk(32'h130, 32'h0, 5'd3, ALU_SUB, 0, 0, 0, 0, 0, 3'd0, 1, 0));
    chk("lui imm", 256'(ex_imm), 256'(32'hABCDE000));
    issue(32'h4030D213, 32'h134, mk(32'h134, 32'h403, 5'd4, ALU_SRA, 1, 0, 0, 0, 0, 3'd5, 1, 0));

    issue(32'h00000000, 32'h138, mk(32'h138, 32'h0, 5'd0, ALU_ADD, 0, 0, 0, 0, 0, 3'd0, 0, ILL));
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("zero word ex_valid", 256'(ex_valid), 256'(1));
    chk("zero word reg_write", 256'(ex_rw), 256'(0));
    chk("zero word illegal", 256'(ex_ill), 256'(ILL));

    drive(1'b1, 32'h00500093, 32'h13C, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre-reset held", 256'(ex_valid), 256'(1));
    reset = 1'b1;
    #1;
    chk("mid reset ex_valid", 256'(ex_valid), 256'(0));
    chk("mid reset ex_pc", 256'(ex_pc), 256'(0));
    @(negedge clk);
    reset = 1'b0;

    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("scoreboard drained", 256'(q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the Jala RV32I pipeline; sits between the fetch buffer and the execute stage.
- Drives the register file read addresses combinationally from the incoming instruction, decodes fields and immediates, and captures everything into a registered ID/EX boundary with valid/ready handshakes.
- Detects load-use hazards and inserts one bubble; honours flush from branch resolution.
- Writeback forwarding is not handled here: the register file provides a same-cycle write-to-read bypass.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0000_0000, value driven on ex_pc while reset is asserted.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- if_valid  in  1  fetch offers an instruction
- if_ready  out  1  stage accepts; combinational
- if_instr  in  32  instruction word
- if_pc  in  32  instruction address
- flush  in  1  kill the held and incoming instruction (taken branch or jump)
- rf_read_addr1  out  5  if_instr[19:15]; combinational
- rf_read_addr2  out  5  if_instr[24:20]; combinational
- rf_read_data1  in  32  rs1 value; same cycle
- rf_read_data2  in  32  rs2 value; same cycle
- ex_ready  in  1  execute accepts the held instruction
- ex_valid  out  1  held instruction valid
- ex_pc  out  32  PC of the held instruction
- ex_rs1_data  out  32  captured rs1 value
- ex_rs2_data  out  32  captured rs2 value
- ex_imm  out  32  sign-extended immediate (I/S/B/U/J)
- ex_rd  out  5  destination register
- ex_alu_op  out  4  ALU operation encoding, from the shared package
- ex_src_imm  out  1  ALU operand B is the immediate
- ex_is_load  out  1  held instruction is a load
- ex_is_store  out  1  held instruction is a store
- ex_is_branch  out  1  held instruction is a branch
- ex_is_jump  out  1  held instruction is JAL or JALR
- ex_funct3  out  3  funct3 field, for branch, load and store width
- ex_reg_write  out  1  writes rd; forced to 0 when rd == 0
- ex_illegal  out  1  only present with the optional feature

Behaviour:
- Reset (async): ex_valid=0; all ex_* outputs 0 except ex_pc=RESET_PC. Reset mid-transfer discards the held instruction.
- Advance condition: adv = !ex_valid || ex_ready.
- Hazard condition: haz = ex_valid && ex_is_load && ex_rd != 0 && ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2)).
  - uses_rs1: R, I-ALU, load, store, branch, JALR.
  - uses_rs2: R, store, branch.
- if_ready = adv && !haz && !flush.
- Priority at each posedge, highest first:
  - flush: ex_valid <= 0; the incoming instruction is dropped (if_ready=0 this cycle, so fetch must re-present).
  - adv && haz: bubble; ex_valid <= 0; the instruction is not accepted. The next cycle the load has left, so haz=0.
  - adv && if_valid: capture all decoded fields and rf data; ex_valid <= 1.
  - adv && !if_valid: ex_valid <= 0.
  - otherwise (ex stalled): hold all ex_* outputs stable.
- Latency: exactly 1 cycle from accept to ex_valid. Back-to-back throughput is 1 instruction per cycle; a load-use pair costs 1 bubble.
- Immediates:
  - I = sext(instr[31:20])
  - S = sext({[31:25],[11:7]})
  - B = sext({[31],[7],[30:25],[11:8],1'b0})
  - U = {[31:12],12'b0}
  - J = sext({[31],[19:12],[20],[30:21],1'b0})
  - R-type: 0.
- LUI: alu_op=PASS_B, src_imm=1. AUIPC, JAL, JALR: execute uses ex_pc.
- SUB/SRA are selected by instr[30] on R-type. SRAI is selected by instr[30] on I-type shifts.
- FENCE, ECALL and EBREAK decode as NOP: valid, reg_write=0.
- Unknown opcode without the optional feature: captured as NOP.
- Simultaneous flush and ex_ready: flush wins; the held instruction is still consumed by execute this cycle.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - ex_illegal port exists.
  - Set for an unknown opcode, a bad funct3/funct7 combination, or instr[1:0] != 2'b11.
  - Illegal instructions are captured with reg_write=0, load=0 and store=0.
- Undefined:
  - No ex_illegal port.
  - Illegal encodings silently become NOPs.

Decomposition:
- Package jala_pkg holds:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM);
  - the ALU_* 4-bit encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B).
- One combinational sub-module, imm_gen (instr to 32-bit immediate), reused later by the branch unit. Everything else stays in decode_stage.

Test Plan:
- Reset and single instruction:
  - Stimulus: reset high, then low; ADDI x5,x0,-1 (0xFFF00293) with rf data 0.
  - Required: ex_valid=0 during reset. One cycle after accept: ex_imm=0xFFFFFFFF, ex_rd=5, ex_alu_op=ADD, ex_src_imm=1, ex_reg_write=1.
- Load-use:
  - Stimulus: LW x6,0(x1) then ADD x7,x6,x2, both presented back-to-back.
  - Required: if_ready=0 for exactly 1 cycle; one bubble (ex_valid=0) between them; the ADD is captured on the following cycle. The same pair with rd=x0 gives no bubble.
- Backpressure:
  - Stimulus: ex_ready=0 for 3 cycles while holding SW x2,8(x1).
  - Required: all ex_* outputs stable; if_ready=0; on release, the next instruction is captured in the same cycle.
- Flush:
  - Stimulus: flush pulsed with if_valid=1 and ex_valid=1.
  - Required: next cycle ex_valid=0; the incoming instruction is not accepted; the instruction after it is accepted normally.
- Immediate formats:
  - BEQ offset -4 gives ex_imm=0xFFFFFFFC.
  - JAL offset +2048 gives ex_imm=0x00000800.
  - LUI 0xABCDE gives ex_imm=0xABCDE000.
- Illegal encoding (DECODE_ILLEGAL_TRAP_EN defined):
  - Stimulus: 0x00000000 presented.
  - Required: ex_illegal=1, ex_reg_write=0. With the macro undefined, the same word gives ex_valid=1 and ex_reg_write=0.
